crosshair_datapath: RTL and testbench
=====================================

// Module: crosshair_datapath
// PURPOSE
//  Responder side of the movement command bus: executes each 4-bit STATE command issued by the
//  movement FSM. Holds the crosshair position, sweeps a BOXxBOX pixel window to erase (CLEAR) or
//  plot (DRAW) the crosshair, and applies one STEP move per LEFT/RIGHT/UP/DOWN command.
//  Returns doneDrawing to the FSM and drives the VGA adapter plot port and hit-detection position.
// PARAMETERS
//  SCREEN_W  160     screen width in pixels (x range 0..SCREEN_W-1)
//  SCREEN_H  120     screen height in pixels (y range 0..SCREEN_H-1)
//  BOX       8       sprite window edge in pixels (power of 2)
//  STEP      4       pixels moved per move command
//  START_X   76      x of window top-left after reset
//  START_Y   56      y of window top-left after reset
//  FG        3'b111  crosshair colour;  BG  3'b000  erase colour
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  STATE        in   4  command: 0100 PREHOLD, 0000 HOLD, 0001 CLEAR, 0011 LEFT, 0010 RIGHT,
//                       0110 DOWN, 0111 UP, 0101 DRAW
//  doneDrawing  out  1  current CLEAR/DRAW sweep complete (see handshake)
//  vga_x        out  8  pixel x to VGA adapter
//  vga_y        out  7  pixel y to VGA adapter
//  colour       out  3  pixel colour
//  plot         out  1  write-enable for vga_x/vga_y/colour this cycle
//  pos_x        out  8  current window top-left x
//  pos_y        out  7  current window top-left y
// BEHAVIOUR
//  Reset: pos_x=START_X, pos_y=START_Y, plot=0, vga_x=0, vga_y=0, colour=0, doneDrawing=0, sweep idle.
//  prev_cmd register samples STATE every cycle (reset 0000); "entry" = STATE != prev_cmd.
//  Internal FSM: IDLE, SWEEP, DONE. Counter cnt is $clog2(BOX*BOX) bits; col=cnt[low], row=cnt[high].
//  IDLE/DONE + entry to CLEAR or DRAW -> SWEEP, cnt=0, sweep_cmd=STATE.
//  SWEEP: one pixel per cycle, registered outputs: vga_x=pos_x+col, vga_y=pos_y+row.
//   CLEAR: plot=1 every pixel, colour=BG (BOX*BOX writes).
//   DRAW: plot=1 only where col==BOX/2 or row==BOX/2, colour=FG; other pixels plot=0, cycle still used.
//   First pixel visible on outputs the cycle after entry; last at entry+BOX*BOX cycles.
//   cnt==BOX*BOX-1 -> DONE next edge, plot=0.
//  DONE: doneDrawing = done_state && (STATE == sweep_cmd), combinational from registers + STATE, so it
//   drops in the same cycle STATE changes (required for direct CLEAR->DRAW; no stale done).
//  Command change during SWEEP: abort, plot=0 next edge; if new command is CLEAR/DRAW restart at cnt=0.
//  Moves: on entry only, one update per entry regardless of dwell length, no plot:
//   LEFT  pos_x = (pos_x<STEP) ? 0 : pos_x-STEP;  RIGHT pos_x = min(pos_x+STEP, SCREEN_W-BOX)
//   UP    pos_y = (pos_y<STEP) ? 0 : pos_y-STEP;  DOWN  pos_y = min(pos_y+STEP, SCREEN_H-BOX)
//   Compute in width+1 bits; no wrap-around. pos_* never changes during SWEEP.
//  HOLD/PREHOLD: plot=0, position held, doneDrawing=0.
//  Reset mid-sweep: all outputs to reset values immediately; position returns to START.
// TESTING
//  Reset, STATE=CLEAR -> 64 cycles plot=1 colour=0 covering x 76..83, y 56..63, then doneDrawing=1.
//  CLEAR done, STATE=RIGHT 1 cycle -> pos_x=80 next edge; then DRAW -> 15 plots colour=7,
//   x=84 column y 56..63 and y=60 row x 80..87, doneDrawing=1 after cycle 64.
//  CLEAR done then STATE=DRAW directly -> doneDrawing=0 in that same cycle, full sweep follows.
//  Clamp: pos_x=2 LEFT -> 0; pos_x=152 RIGHT -> 152; pos_y=112 DOWN -> 112; pos_y=0 UP -> 0.
//  RIGHT held 5 cycles -> pos_x +4 once only; HOLD -> no plots, done=0.
//  reset pulse at sweep pixel 20 -> plot=0, done=0, pos=(76,56) at once; CLEAR restarts full 64.

Source files
------------

// File: rtl/crosshair_datapath_if.sv
// Movement command bus between the movement FSM (master) and the crosshair datapath (slave).
// Also carries the VGA plot port and the hit-detection position.
interface crosshair_datapath_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7
);
  logic [3:0]    STATE;
  logic          doneDrawing;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [2:0]    colour;
  logic          plot;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;

  modport master (
    output STATE,
    input  doneDrawing, vga_x, vga_y, colour, plot, pos_x, pos_y
  );

  modport slave (
    input  STATE,
    output doneDrawing, vga_x, vga_y, colour, plot, pos_x, pos_y
  );
endinterface

// File: rtl/crosshair_datapath.sv
// Crosshair datapath: executes movement-FSM commands, holds the window position and sweeps a
// BOXxBOX window one pixel per cycle to erase (CLEAR) or plot (DRAW) the crosshair.
module crosshair_datapath #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120,
  parameter int unsigned BOX      = 8,
  parameter int unsigned STEP     = 4,
  parameter int unsigned START_X  = 76,
  parameter int unsigned START_Y  = 56,
  parameter logic [2:0]  FG       = 3'b111,
  parameter logic [2:0]  BG       = 3'b000
) (
  input logic            clk,
  input logic            reset,
  crosshair_datapath_if.slave bus
);

  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = $clog2(BOX * BOX);
  localparam int unsigned HW = $clog2(BOX);

  localparam logic [3:0] CMD_CLEAR = 4'b0001;
  localparam logic [3:0] CMD_LEFT  = 4'b0011;
  localparam logic [3:0] CMD_RIGHT = 4'b0010;
  localparam logic [3:0] CMD_DOWN  = 4'b0110;
  localparam logic [3:0] CMD_UP    = 4'b0111;
  localparam logic [3:0] CMD_DRAW  = 4'b0101;

  localparam logic [CW-1:0] LAST_PIX = CW'(BOX * BOX - 1);
  localparam logic [HW-1:0] MID      = HW'(BOX / 2);
  localparam logic [XW-1:0] MAX_X    = XW'(SCREEN_W - BOX);
  localparam logic [YW-1:0] MAX_Y    = YW'(SCREEN_H - BOX);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t        state;
  logic [3:0]    prev_cmd;
  logic [3:0]    sweep_cmd;
  logic [CW-1:0] cnt;
  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [2:0]    colour;
  logic          plot;

  logic          entry_c;
  logic          start_c;
  logic [3:0]    pix_cmd_c;
  logic [CW-1:0] pix_c;
  logic [HW-1:0] pix_col_c;
  logic [HW-1:0] pix_row_c;
  logic          pix_on_c;
  logic [XW:0]   right_c;
  logic [YW:0]   down_c;

  // A new CLEAR/DRAW command starts (or restarts) a sweep from pixel 0 in any state.
  assign entry_c   = (bus.STATE != prev_cmd);
  assign start_c   = entry_c && ((bus.STATE == CMD_CLEAR) || (bus.STATE == CMD_DRAW));
  assign pix_cmd_c = start_c ? bus.STATE : sweep_cmd;
  assign pix_c     = start_c ? '0 : cnt + CW'(1);
  assign pix_col_c = pix_c[HW-1:0];
  assign pix_row_c = pix_c[CW-1:HW];
  assign pix_on_c  = (pix_cmd_c == CMD_CLEAR) || (pix_col_c == MID) || (pix_row_c == MID);

  // One bit of headroom so the clamp sees the true sum.
  assign right_c = {1'b0, pos_x} + (XW+1)'(STEP);
  assign down_c  = {1'b0, pos_y} + (YW+1)'(STEP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prev_cmd  <= 4'b0000;
      sweep_cmd <= 4'b0000;
      cnt       <= '0;
      pos_x     <= XW'(START_X);
      pos_y     <= YW'(START_Y);
      vga_x     <= '0;
      vga_y     <= '0;
      colour    <= 3'b000;
      plot      <= 1'b0;
    end else begin
      prev_cmd <= bus.STATE;

      if (start_c) begin
        state     <= SWEEP;
        cnt       <= '0;
        sweep_cmd <= bus.STATE;
        plot      <= pix_on_c;
        vga_x     <= pos_x + XW'(pix_col_c);
        vga_y     <= pos_y + YW'(pix_row_c);
        colour    <= (pix_cmd_c == CMD_CLEAR) ? BG : FG;
      end else begin
        case (state)
          SWEEP: begin
            if (entry_c) begin
              state <= IDLE;
              plot  <= 1'b0;
            end else if (cnt == LAST_PIX) begin
              state <= DONE;
              plot  <= 1'b0;
            end else begin
              cnt    <= pix_c;
              plot   <= pix_on_c;
              vga_x  <= pos_x + XW'(pix_col_c);
              vga_y  <= pos_y + YW'(pix_row_c);
              colour <= (pix_cmd_c == CMD_CLEAR) ? BG : FG;
            end
          end
          DONE: begin
            if (entry_c) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end

      // Exactly one step per command entry, saturating at the screen edges.
      if (entry_c) begin
        case (bus.STATE)
          CMD_LEFT:  pos_x <= (pos_x < XW'(STEP)) ? '0 : pos_x - XW'(STEP);
          CMD_RIGHT: pos_x <= (right_c > (XW+1)'(MAX_X)) ? MAX_X : right_c[XW-1:0];
          CMD_UP:    pos_y <= (pos_y < YW'(STEP)) ? '0 : pos_y - YW'(STEP);
          CMD_DOWN:  pos_y <= (down_c > (YW+1)'(MAX_Y)) ? MAX_Y : down_c[YW-1:0];
          default:   ;
        endcase
      end
    end
  end

  // Done is qualified by the live command so it drops the moment the FSM moves on.
  assign bus.doneDrawing = (state == DONE) && (bus.STATE == sweep_cmd);
  assign bus.vga_x       = vga_x;
  assign bus.vga_y       = vga_y;
  assign bus.colour      = colour;
  assign bus.plot        = plot;
  assign bus.pos_x       = pos_x;
  assign bus.pos_y       = pos_y;

endmodule

// File: tb/tb_crosshair_datapath.sv
// Self-checking bench for crosshair_datapath: directed sweeps, table of moves/clamps,
// and hand-written abort and mid-sweep reset sequences.
module tb_crosshair_datapath;

  localparam logic [3:0] HOLD  = 4'b0000;
  localparam logic [3:0] CLEAR = 4'b0001;
  localparam logic [3:0] LEFT  = 4'b0011;
  localparam logic [3:0] RIGHT = 4'b0010;
  localparam logic [3:0] DOWN  = 4'b0110;
  localparam logic [3:0] UP    = 4'b0111;
  localparam logic [3:0] DRAW  = 4'b0101;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  crosshair_datapath_if bus ();

  crosshair_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] cmd;
    int         reps;
    int         ex;
    int         ey;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic move(input logic [3:0] cmd);
    bus.STATE = cmd;
    step();
    bus.STATE = HOLD;
    step();
  endtask

  // Issues cmd and checks every pixel of the window at (px,py) against the model.
  task automatic sweep(input logic [3:0] cmd, input int px, input int py, input string tag);
    int          plots;
    logic        on;
    logic [2:0]  col;
    logic [18:0] exp;
    logic [18:0] act;
    plots = 0;
    col   = (cmd == CLEAR) ? 3'b000 : 3'b111;
    bus.STATE = cmd;
    for (int k = 0; k < 64; k++) begin
      step();
      on  = (cmd == CLEAR) || (k % 8 == 4) || (k / 8 == 4);
      exp = {on, 8'(px + k % 8), 7'(py + k / 8), on ? col : 3'b000};
      act = {bus.plot, bus.vga_x, bus.vga_y, bus.plot ? bus.colour : 3'b000};
      check($sformatf("%s_pix%0d", tag, k), 32'(act), 32'(exp));
      if (bus.plot === 1'b1) plots++;
    end
    step();
    check({tag, "_plot_after"}, 32'(bus.plot), 32'd0);
    check({tag, "_done"}, 32'(bus.doneDrawing), 32'd1);
    check({tag, "_plot_count"}, 32'(plots), (cmd == CLEAR) ? 32'd64 : 32'd15);
  endtask

  initial begin
    int plots;

    vt[0] = '{LEFT,  21,   0, 56};
    vt[1] = '{LEFT,   1,   0, 56};
    vt[2] = '{RIGHT, 38, 152, 56};
    vt[3] = '{RIGHT,  1, 152, 56};
    vt[4] = '{UP,    14, 152,  0};
    vt[5] = '{UP,     1, 152,  0};
    vt[6] = '{DOWN,  28, 152, 112};
    vt[7] = '{DOWN,   1, 152, 112};
    vt[8] = '{UP,     3, 152, 100};
    vt[9] = '{LEFT,   2, 144, 100};

    bus.STATE = HOLD;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_plot",   32'(bus.plot),        32'd0);
    check("rst_vga_x",  32'(bus.vga_x),       32'd0);
    check("rst_vga_y",  32'(bus.vga_y),       32'd0);
    check("rst_colour", 32'(bus.colour),      32'd0);
    check("rst_done",   32'(bus.doneDrawing), 32'd0);
    check("rst_pos_x",  32'(bus.pos_x),       32'd76);
    check("rst_pos_y",  32'(bus.pos_y),       32'd56);
    reset = 1'b0;
    step();

    sweep(CLEAR, 76, 56, "clear0");

    bus.STATE = RIGHT;
    #1;
    check("right_done_drop", 32'(bus.doneDrawing), 32'd0);
    step();
    check("right_pos_x", 32'(bus.pos_x), 32'd80);
    sweep(DRAW, 80, 56, "draw0");

    bus.STATE = HOLD;
    step();
    sweep(CLEAR, 80, 56, "clear1");
    bus.STATE = DRAW;
    #1;
    check("direct_draw_done", 32'(bus.doneDrawing), 32'd0);
    sweep(DRAW, 80, 56, "draw1");

    bus.STATE = RIGHT;
    repeat (5) step();
    check("right_held_x", 32'(bus.pos_x), 32'd84);
    bus.STATE = HOLD;
    plots = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.plot === 1'b1) plots++;
    end
    check("hold_plots", 32'(plots), 32'd0);
    check("hold_done",  32'(bus.doneDrawing), 32'd0);

    for (int v = 0; v < 10; v++) begin
      for (int r = 0; r < vt[v].reps; r++) move(vt[v].cmd);
      check($sformatf("vec%0d_pos_x", v), 32'(bus.pos_x), 32'(vt[v].ex));
      check($sformatf("vec%0d_pos_y", v), 32'(bus.pos_y), 32'(vt[v].ey));
    end

    bus.STATE = CLEAR;
    repeat (6) step();
    check("abort_plot_on", 32'(bus.plot), 32'd1);
    bus.STATE = HOLD;
    step();
    check("abort_plot_off", 32'(bus.plot), 32'd0);
    step();
    check("abort_done", 32'(bus.doneDrawing), 32'd0);
    check("abort_pos_x", 32'(bus.pos_x), 32'd144);

    bus.STATE = CLEAR;
    repeat (21) step();
    check("pre_rst_pix20", 32'({bus.plot, bus.vga_x, bus.vga_y}), 32'({1'b1, 8'd148, 7'd102}));
    reset = 1'b1;
    #1;
    check("mid_rst_plot",  32'(bus.plot),        32'd0);
    check("mid_rst_done",  32'(bus.doneDrawing), 32'd0);
    check("mid_rst_pos_x", 32'(bus.pos_x),       32'd76);
    check("mid_rst_pos_y", 32'(bus.pos_y),       32'd56);
    check("mid_rst_vga_x", 32'(bus.vga_x),       32'd0);
    step();
    reset = 1'b0;
    sweep(CLEAR, 76, 56, "clear_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
